// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit multiply/divide sequencer driving the HI/LO write path
//   clk       in  1  : rising-edge clock
//   rst       in  1  : asynchronous active-high reset
//   start     in  1  : EX holds a mul/div op, held until accepted
//   funct     in  2  : 00 mult, 01 multu, 10 div, 11 divu
//   src_a     in  32 : multiplicand / dividend
//   src_b     in  32 : multiplier / divisor
//   hilo_read in  1  : EX holds mfhi/mflo/mthi/mtlo
//   flush     in  1  : abort any in-flight op
//   busy      out 1  : op in RUN or DONE
//   stall     out 1  : freeze IF/ID/EX
//   multWe    out 1  : one-cycle HI/LO write strobe
//   busmult   out 64 : {HI, LO} result
module muldiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  funct,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        hilo_read,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic        multWe,
   output logic [63:0] busmult
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic        is_div, sign_a, sign_b;
   logic [4:0]  cnt;
   logic [31:0] opnd;
   logic [63:0] acc, res;
   logic        is_signed, div_zero, accept, neg;
   logic [31:0] abs_a, abs_b, quo, rem;
   logic [32:0] mul_sum;
   logic [33:0] div_diff;
   logic [63:0] mul_n, div_n, prod, fixed;
   assign is_signed = ~funct[0];
   assign abs_a     = (is_signed & src_a[31]) ? -src_a : src_a;
   assign abs_b     = (is_signed & src_b[31]) ? -src_b : src_b;
   assign div_zero  = funct[1] & (src_b == 32'd0);
   assign accept    = (state == IDLE) & start & ~flush;
   // multiply: acc = {product_hi, multiplier}; add into upper half, shift right
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
   assign mul_n   = {mul_sum, acc[31:1]};
   // divide: acc = {rem, quot}; the shifted remainder needs 33 bits before the trial subtract
   assign div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
   assign div_n    = {div_diff[33] ? acc[62:31] : div_diff[31:0], acc[30:0], ~div_diff[33]};
   // sign fix-up on the unsigned magnitudes; remainder follows the dividend
   assign neg   = sign_a ^ sign_b;
   assign prod  = neg ? -acc : acc;
   assign quo   = neg ? -acc[31:0] : acc[31:0];
   assign rem   = sign_a ? -acc[63:32] : acc[63:32];
   assign fixed = is_div ? {rem, quo} : prod;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = flush              ? IDLE :
                (state == IDLE)    ? (start ? (div_zero ? DONE : RUN) : IDLE) :
                (state == RUN)     ? ((cnt == 5'd0) ? DONE : RUN) :
                                     IDLE;
   end
   always_comb begin
      busy    = state != IDLE;
      stall   = busy & (start | hilo_read);
      multWe  = (state == DONE) & ~flush;
      busmult = (state == DONE) ? fixed : res;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         cnt    <= 5'd0;
         opnd   <= 32'd0;
         acc    <= 64'd0;
         res    <= 64'd0;
      end else begin
         if (accept) begin
            is_div <= funct[1];
            // divide by zero bypasses the fix-up so HI keeps the raw dividend
            sign_a <= is_signed & src_a[31] & ~div_zero;
            sign_b <= is_signed & src_b[31] & ~div_zero;
            cnt    <= 5'd31;
            opnd   <= funct[1] ? abs_b : abs_a;
            acc    <= div_zero ? {src_a, 32'hFFFF_FFFF} : {32'd0, funct[1] ? abs_a : abs_b};
         end else if (state == RUN) begin
            acc <= is_div ? div_n : mul_n;
            cnt <= cnt - 5'd1;
         end
         if (multWe) res <= fixed;
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  funct = 2'b00;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        hilo_read = 1'b0;
   logic        flush = 1'b0;
   logic        busy, stall, multWe;
   logic [63:0] busmult;
   int          checks = 0;
   int          errors = 0;
   logic        seen;

   muldiv_seq dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct), .src_a(src_a), .src_b(src_b),
      .hilo_read(hilo_read), .flush(flush), .busy(busy), .stall(stall), .multWe(multWe),
      .busmult(busmult)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // leaves the bench 1 time unit after the accept edge E0
   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; funct = f; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
      int n;
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) check({tag, " busy"}, {63'd0, busy}, 64'd1);
         if (multWe) begin
            n = i;
            break;
         end
      end
      check({tag, " lat"}, 64'(n), 64'(lat));
      check({tag, " res"}, busmult, exp);
      @(negedge clk);
      check({tag, " we_off"}, {63'd0, multWe}, 64'd0);
      check({tag, " idle"}, {63'd0, busy}, 64'd0);
      check({tag, " hold"}, busmult, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst busy", {63'd0, busy}, 64'd0);
      check("rst we", {63'd0, multWe}, 64'd0);
      check("rst bus", busmult, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu max", 33, 64'hFFFF_FFFE_0000_0001);
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done("mult -3*5", 33, 64'hFFFF_FFFF_FFFF_FFF1);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_done("mult min*min", 33, 64'h4000_0000_0000_0000);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done("div -7/2", 33, 64'hFFFF_FFFF_FFFF_FFFD);
      issue(2'b10, 32'd7, 32'hFFFF_FFFE);
      wait_done("div 7/-2", 33, 64'h0000_0001_FFFF_FFFD);
      issue(2'b11, 32'd100, 32'd7);
      wait_done("divu 100/7", 33, 64'h0000_0002_0000_000E);
      issue(2'b11, 32'd5, 32'd0);
      wait_done("divu 5/0", 1, 64'h0000_0005_FFFF_FFFF);
      issue(2'b10, 32'hFFFF_FFF9, 32'd0);
      wait_done("div -7/0", 1, 64'hFFFF_FFF9_FFFF_FFFF);

      // hilo_read from E5 through completion
      issue(2'b01, 32'd7, 32'd6);
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         if (n <= 4) check("hilo pre", {63'd0, stall}, 64'd0);
         else if (n <= 33) check("hilo stall", {63'd0, stall}, 64'd1);
         else check("hilo after", {63'd0, stall}, 64'd0);
         if (n == 33) begin
            check("hilo we", {63'd0, multWe}, 64'd1);
            check("hilo res", busmult, 64'd42);
         end
         if (n == 4) hilo_read = 1'b1;
      end
      hilo_read = 1'b0;

      // second start held through the run: one bubble after DONE
      @(posedge clk); #1;
      start = 1'b1; funct = 2'b01; src_a = 32'd3; src_b = 32'd3;
      @(posedge clk); #1;
      funct = 2'b11; src_a = 32'h1234_5678; src_b = 32'h100;
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         if (n <= 33) check("b2b stall", {63'd0, stall}, 64'd1);
         if (n == 33) check("b2b res1", busmult, 64'd9);
         if (n == 34) begin
            check("b2b bubble", {63'd0, busy}, 64'd0);
            check("b2b nostall", {63'd0, stall}, 64'd0);
         end
      end
      @(posedge clk); #1 start = 1'b0;
      wait_done("b2b divu", 33, 64'h0000_0078_0012_3456);

      // flush during RUN
      issue(2'b00, 32'd9, 32'd9);
      seen = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         seen = seen | multWe;
         if (n == 11) begin
            check("flush run busy", {63'd0, busy}, 64'd1);
            flush = 1'b1;
         end
         if (n == 12) begin
            check("flush idle", {63'd0, busy}, 64'd0);
            flush = 1'b0;
         end
      end
      check("flush no we", {63'd0, seen}, 64'd0);

      // flush during DONE
      issue(2'b11, 32'd8, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      check("flush done we", {63'd0, multWe}, 64'd0);
      check("flush done busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush done idle", {63'd0, busy}, 64'd0);
      check("flush done bus", busmult, 64'h0000_0078_0012_3456);

      // flush with start in IDLE is not accepted
      @(posedge clk); #1 start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush start", {63'd0, busy}, 64'd0);

      // asynchronous reset mid-run
      issue(2'b01, 32'hFFFF_FFFF, 32'd2);
      repeat (20) @(posedge clk);
      hilo_read = 1'b1;
      #3 rst = 1'b1;
      #1;
      check("arst busy", {63'd0, busy}, 64'd0);
      check("arst stall", {63'd0, stall}, 64'd0);
      check("arst we", {63'd0, multWe}, 64'd0);
      check("arst bus", busmult, 64'd0);
      hilo_read = 1'b0;
      @(negedge clk) rst = 1'b0;
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("post rst", 33, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
